i2s_rx_capture: RTL

I2S microphone receiver at the front of the i2s path: samples SCK/WS/SD in the system clock domain, deserialises each slot MSB-first into a DATA_W-bit word tagged with its channel, and buffers completed words in a small FIFO. A valid/ready port delivers the words to the summing stage, and the summing stage's result feeds the output shift chain.

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_rx_fifo.sv | 51 +++++
 rtl/i2s_rx_capture.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the I2S receive path: default widths, channel tag and captured-word layout.
package i2s_pkg;

  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned SLOT_W_DEF = 32;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

  typedef struct packed {
    chan_t                 chan;
    logic [DATA_W_DEF-1:0] data;
  } rx_word_t;

  typedef enum logic {
    CAP_UNPRIMED = 1'b0,
    CAP_PRIMED   = 1'b1
  } cap_state_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous FIFO of captured words; a push into a full FIFO is accepted only alongside a pop.
module i2s_rx_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = rx_word_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t wdata_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S receiver: conditions SCK/WS/SD, deserialises each slot MSB-first and queues tagged words.
// I2S_RX_SYNC_EN adds a 2-flop synchroniser on each pin; otherwise pins are registered once.
module i2s_rx_capture
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned SLOT_W     = SLOT_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ws,
  input  logic              sd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_chan,
  output logic              ovf,
  output logic              frame_err
);

  localparam int unsigned CW = $clog2(SLOT_W + 1);

  typedef struct packed {
    chan_t             chan;
    logic [DATA_W-1:0] data;
  } word_t;

  logic sck_c, ws_c, sd_c;

`ifdef I2S_RX_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sck, ws, sd};
      sync2_q <= sync1_q;
    end
  end

  assign {sck_c, ws_c, sd_c} = sync2_q;
`else
  assign {sck_c, ws_c, sd_c} = {sck, ws, sd};
`endif

  logic sck_prev_q, rise_q, ws_q, sd_q;

  // Edge register: ws/sd travel with the rise pulse so they are sampled on the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_prev_q <= 1'b0;
      rise_q     <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
    end else begin
      sck_prev_q <= sck_c;
      rise_q     <= sck_c & ~sck_prev_q;
      ws_q       <= ws_c;
      sd_q       <= sd_c;
    end
  end

  logic [DATA_W-1:0] sh_q, sh_d, sh_shift;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  chan_t             ws_last_q, ws_last_d;
  cap_state_t        state_q, state_d;
  word_t             word_q, word_d;
  logic              push_q, push_d, ferr_q, ferr_d;
  logic              ws_chg, slot_ok, ovf_q;
  logic              fifo_full, fifo_empty, pop;
  word_t             head;

  always_comb begin
    sh_shift = (cnt_q < CW'(DATA_W)) ? {sh_q[DATA_W-2:0], sd_q} : sh_q;
    cnt_inc  = (cnt_q == CW'(SLOT_W)) ? cnt_q : cnt_q + CW'(1);
    ws_chg   = rise_q && (ws_q != ws_last_q);
    // The WS-change rise still carries the last bit of the closing slot.
    slot_ok  = (cnt_inc >= CW'(DATA_W));
  end

  always_comb begin
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    ws_last_d = ws_last_q;
    if (rise_q) begin
      sh_d  = sh_shift;
      cnt_d = ws_chg ? '0 : cnt_inc;
    end
    if (ws_chg) ws_last_d = chan_t'(ws_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= CAP_UNPRIMED;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CAP_UNPRIMED: if (ws_chg) state_d = CAP_PRIMED;
      default:      state_d = state_q;
    endcase
  end

  always_comb begin
    push_d = 1'b0;
    ferr_d = 1'b0;
    word_d = '{chan: ws_last_q, data: sh_shift};
    if (state_q == CAP_PRIMED && ws_chg) begin
      push_d = slot_ok;
      ferr_d = !slot_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q      <= '0;
      cnt_q     <= '0;
      ws_last_q <= CH_LEFT;
      push_q    <= 1'b0;
      ferr_q    <= 1'b0;
      word_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      ws_last_q <= ws_last_d;
      push_q    <= push_d;
      ferr_q    <= ferr_d;
      if (push_d) word_q <= word_d;
      if (push_q && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  i2s_rx_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (word_t)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push_q),
    .pop_i   (pop),
    .wdata_i (word_q),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? head.data : '0;
  assign out_chan  = out_valid ? head.chan : 1'b0;
  assign ovf       = ovf_q;
  assign frame_err = ferr_q;

endmodule
